pc_sequencer: RTL and testbench

//  Next-generation program-counter unit for the MIPS datapath: owns the PC register and selects the next PC.

---
 rtl/mips_pc_pkg.sv | 26 ++
 rtl/pc_target_calc.sv | 41 ++++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pc_pkg.sv
// ----------------------------------------------------------------------------
// mips_pc_pkg
// Shared types and default vectors for the MIPS program-counter sequencer.
//   pc_sel_e     : which next-PC candidate wins in a cycle
//   dly_state_e  : branch-delay FSM state (IDLE / PEND)
//   DEF_RESET_VEC, DEF_TRAP_VEC : 32-bit default reset and trap vectors
// ----------------------------------------------------------------------------
package mips_pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_TRAP
    } pc_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } dly_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/pc_target_calc.sv
// ----------------------------------------------------------------------------
// pc_target_calc
// Combinational next-PC candidate generator.
//   pc_i            : current PC
//   branch_imm_i    : signed 16-bit branch offset, in words
//   jump_index_i    : J-type instruction index field
//   jr_target_i     : register-sourced jump target
//   pc_plus4_o      : pc + 4 (wraps modulo 2^WIDTH)
//   br_t_o          : pc + 4 + sext(imm) * 4
//   j_t_o           : {upper REGION_BITS of pc+4, index, 2'b00}
//   jr_misalign_o   : jr target is not word aligned
// ----------------------------------------------------------------------------
module pc_target_calc #(
    parameter int WIDTH       = 32,
    parameter int REGION_BITS = 4,
    localparam int IDX_W      = WIDTH - REGION_BITS - 2
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [15:0]      branch_imm_i,
    input  logic [IDX_W-1:0] jump_index_i,
    input  logic [WIDTH-1:0] jr_target_i,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic [WIDTH-1:0] br_t_o,
    output logic [WIDTH-1:0] j_t_o,
    output logic             jr_misalign_o
);

    logic [WIDTH-1:0] br_off;

    assign pc_plus4_o = pc_i + WIDTH'(4);

    // Sign-extend the word offset and convert it to a byte offset in one step.
    assign br_off = {{(WIDTH-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};
    assign br_t_o = pc_plus4_o + br_off;

    // The jump stays inside the region of the delay-slot instruction (pc+4).
    assign j_t_o = {pc_plus4_o[WIDTH-1 -: REGION_BITS], jump_index_i, 2'b00};

    assign jr_misalign_o = |jr_target_i[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-counter register and next-PC selection for the MIPS datapath.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   stall            : hold PC, pending redirect and sticky flags
//   jump_en/index    : J/JAL request and its instruction index
//   branch_en/taken/imm : branch request, condition and word offset
//   jr_en/jr_target  : JR/JALR request and its register target
//   pc, pc_plus4     : current PC and its sequential successor
//   delay_pending    : current pc is a delay-slot instruction (DELAY_SLOT=1)
//   misalign_err     : sticky, a misaligned jr target was trapped
//   slot_err         : sticky, a redirect arrived inside a delay slot
// ----------------------------------------------------------------------------
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               REGION_BITS = 4,
    parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC    = WIDTH'(DEF_TRAP_VEC),
    parameter int               DELAY_SLOT  = 0,
    localparam int              IDX_W       = WIDTH - REGION_BITS - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [IDX_W-1:0] jump_index,
    input  logic             branch_en,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jr_en,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             delay_pending,
    output logic             misalign_err,
    output logic             slot_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    dly_state_e       state_q, state_d;
    logic             mis_q, mis_d;
    logic             slot_q, slot_d;

    logic [WIDTH-1:0] br_t, j_t, redir_tgt;
    logic             jr_misalign;
    logic             redirect;
    pc_sel_e          sel;

    pc_target_calc #(
        .WIDTH       (WIDTH),
        .REGION_BITS (REGION_BITS)
    ) u_calc (
        .pc_i          (pc_q),
        .branch_imm_i  (branch_imm),
        .jump_index_i  (jump_index),
        .jr_target_i   (jr_target),
        .pc_plus4_o    (pc_plus4),
        .br_t_o        (br_t),
        .j_t_o         (j_t),
        .jr_misalign_o (jr_misalign)
    );

    // Fixed priority: jr > jump > taken branch > sequential.
    always_comb begin
        sel       = SEL_SEQ;
        redir_tgt = pc_plus4;
        if (jr_en) begin
            sel       = jr_misalign ? SEL_TRAP : SEL_JR;
            redir_tgt = jr_target;
        end else if (jump_en) begin
            sel       = SEL_J;
            redir_tgt = j_t;
        end else if (branch_en && branch_taken) begin
            sel       = SEL_BR;
            redir_tgt = br_t;
        end
    end

    assign redirect = (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR);

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a value unassigned and infers a latch.
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        mis_d   = mis_q;
        slot_d  = slot_q;
        if (!stall) begin
            if (sel == SEL_TRAP) begin
                // The trap bypasses the delay slot and cancels any pending redirect.
                pc_d    = TRAP_VEC;
                tgt_d   = '0;
                state_d = ST_IDLE;
                mis_d   = 1'b1;
            end else if (DELAY_SLOT == 0) begin
                pc_d = redirect ? redir_tgt : pc_plus4;
            end else if (state_q == ST_PEND) begin
                // The slot instruction is executing; a new redirect here is illegal.
                pc_d    = tgt_q;
                state_d = ST_IDLE;
                if (redirect) begin
                    slot_d = 1'b1;
                end
            end else if (redirect) begin
                pc_d    = pc_plus4;
                tgt_d   = redir_tgt;
                state_d = ST_PEND;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            tgt_q   <= '0;
            state_q <= ST_IDLE;
            mis_q   <= 1'b0;
            slot_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
            mis_q   <= mis_d;
            slot_q  <= slot_d;
        end
    end

    assign pc            = pc_q;
    assign delay_pending = (state_q == ST_PEND);
    assign misalign_err  = mis_q;
    assign slot_err      = slot_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Drives a DELAY_SLOT=0 and a DELAY_SLOT=1 instance with the same request
// stream and compares both against a behavioural model every cycle, plus
// directed checks on the documented scenarios.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        jump_en, branch_en, branch_taken, jr_en;
    logic [25:0] jump_index;
    logic [15:0] branch_imm;
    logic [31:0] jr_target;

    logic [31:0] pc [2];
    logic [31:0] pc_plus4 [2];
    logic        delay_pending [2];
    logic        misalign_err [2];
    logic        slot_err [2];

    // Reference model state, index = DELAY_SLOT value.
    logic [31:0] m_pc [2];
    logic [31:0] m_tgt [2];
    bit          m_pend [2];
    bit          m_mis [2];
    bit          m_slot [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.DELAY_SLOT(0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall),
        .jump_en(jump_en), .jump_index(jump_index),
        .branch_en(branch_en), .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jr_en(jr_en), .jr_target(jr_target),
        .pc(pc[0]), .pc_plus4(pc_plus4[0]), .delay_pending(delay_pending[0]),
        .misalign_err(misalign_err[0]), .slot_err(slot_err[0])
    );

    pc_sequencer #(.DELAY_SLOT(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall),
        .jump_en(jump_en), .jump_index(jump_index),
        .branch_en(branch_en), .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jr_en(jr_en), .jr_target(jr_target),
        .pc(pc[1]), .pc_plus4(pc_plus4[1]), .delay_pending(delay_pending[1]),
        .misalign_err(misalign_err[1]), .slot_err(slot_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle of the architectural rules for the selected delay mode.
    task automatic model_step(input int m);
        logic [31:0]        p4, t;
        logic signed [31:0] off;
        bit                 req, trap;
        p4   = m_pc[m] + 32'd4;
        off  = 32'($signed(branch_imm));
        req  = 1'b1;
        trap = 1'b0;
        t    = 32'd0;
        if (jr_en) begin
            t    = jr_target;
            trap = (jr_target % 4) != 0;
        end else if (jump_en) begin
            t = (p4 & 32'hF000_0000) | ({6'd0, jump_index} * 4);
        end else if (branch_en && branch_taken) begin
            t = p4 + 32'(off * 4);
        end else begin
            req = 1'b0;
        end

        if (reset) begin
            m_pc[m] = 32'h0; m_tgt[m] = 32'h0; m_pend[m] = 0; m_mis[m] = 0; m_slot[m] = 0;
        end else if (stall) begin
            // everything holds
        end else if (trap) begin
            m_pc[m] = 32'h80; m_pend[m] = 0; m_mis[m] = 1;
        end else if (m == 0) begin
            m_pc[m] = req ? t : p4;
        end else if (m_pend[m]) begin
            m_pc[m] = m_tgt[m]; m_pend[m] = 0;
            if (req) m_slot[m] = 1;
        end else if (req) begin
            m_pc[m] = p4; m_tgt[m] = t; m_pend[m] = 1;
        end else begin
            m_pc[m] = p4;
        end
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; jump_en = 0; branch_en = 0; branch_taken = 0; jr_en = 0;
        jump_index = '0; branch_imm = '0; jr_target = '0;
    endtask

    // Clock edge, model update, then compare both instances to the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            model_step(m);
            check($sformatf("pc[ds%0d]", m), pc[m], m_pc[m]);
            check($sformatf("pc_plus4[ds%0d]", m), pc_plus4[m], m_pc[m] + 32'd4);
            check($sformatf("delay_pending[ds%0d]", m), 32'(delay_pending[m]), 32'(m_pend[m]));
            check($sformatf("misalign_err[ds%0d]", m), 32'(misalign_err[m]), 32'(m_mis[m]));
            check($sformatf("slot_err[ds%0d]", m), 32'(slot_err[m]), 32'(m_slot[m]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clear_inputs();
            cycle();
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);

        // 1: reset then sequential fetch
        do_reset();
        check("reset_pc", pc[0], 32'h0);
        check("reset_flags", {29'd0, delay_pending[1], misalign_err[1], slot_err[1]}, 32'h0);
        idle(1); check("seq_4", pc[0], 32'h4);
        idle(1); check("seq_8", pc[0], 32'h8);
        idle(1); check("seq_c", pc[0], 32'hC);
        check("seq_flags", {29'd0, delay_pending[0], misalign_err[0], slot_err[0]}, 32'h0);

        // 2: backward branch and in-region jump (DELAY_SLOT=0)
        do_reset();
        clear_inputs(); jr_en = 1; jr_target = 32'h1000_0040; cycle();
        check("jr_setup", pc[0], 32'h1000_0040);
        clear_inputs(); branch_en = 1; branch_taken = 1; branch_imm = 16'hFFFE; cycle();
        check("branch_back", pc[0], 32'h1000_003C);
        clear_inputs(); jump_en = 1; jump_index = 26'h000_0010; cycle();
        check("jump_region", pc[0], 32'h1000_0040);
        // untaken branch falls through
        clear_inputs(); branch_en = 1; branch_taken = 0; branch_imm = 16'h0100; cycle();
        check("branch_not_taken", pc[0], 32'h1000_0044);

        // 3: priority, jr wins over jump and branch
        clear_inputs();
        jr_en = 1; jr_target = 32'h0040_0000;
        jump_en = 1; jump_index = 26'h3FF_FFFF;
        branch_en = 1; branch_taken = 1; branch_imm = 16'h0010;
        cycle();
        check("priority_jr", pc[0], 32'h0040_0000);

        // 4: misaligned jr traps, flag sticks
        clear_inputs(); jr_en = 1; jr_target = 32'h0040_0002; cycle();
        check("trap_pc", pc[0], 32'h80);
        check("trap_flag", 32'(misalign_err[0]), 32'h1);
        idle(10);
        check("trap_sticky", 32'(misalign_err[0]), 32'h1);

        // wrap at the top of the address space
        clear_inputs(); jr_en = 1; jr_target = 32'hFFFF_FFFC; cycle();
        idle(1);
        check("wrap_pc_ds0", pc[0], 32'h0000_0000);

        // 5: delay slot, jump in the slot is dropped and flagged
        do_reset();
        idle(64);
        check("ds1_at_100", pc[1], 32'h100);
        clear_inputs(); jump_en = 1; jump_index = 26'h100; cycle();
        check("ds1_slot_pc", pc[1], 32'h104);
        check("ds1_pending", 32'(delay_pending[1]), 32'h1);
        clear_inputs(); jump_en = 1; jump_index = 26'h300; cycle();
        check("ds1_target", pc[1], 32'h400);
        check("ds1_slot_err", 32'(slot_err[1]), 32'h1);
        idle(1);
        check("ds1_dropped", pc[1], 32'h404);

        // 6: stall inside the slot, then reset inside the slot
        do_reset();
        idle(64);
        clear_inputs(); jump_en = 1; jump_index = 26'h100; cycle();
        check("ds1_pend_again", pc[1], 32'h104);
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); stall = 1; jump_en = 1; jump_index = 26'h200; cycle();
            check("stall_hold", pc[1], 32'h104);
        end
        check("stall_no_slot_err", 32'(slot_err[1]), 32'h0);
        idle(1);
        check("stall_release", pc[1], 32'h400);
        clear_inputs(); jump_en = 1; jump_index = 26'h040; cycle();
        check("pend_before_reset", 32'(delay_pending[1]), 32'h1);
        clear_inputs(); reset = 1; cycle();
        check("reset_in_pend_pc", pc[1], 32'h0);
        check("reset_in_pend_flag", 32'(delay_pending[1]), 32'h0);
        idle(2);
        check("reset_discards", pc[1], 32'h8);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 79) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            jr_en        = ($urandom_range(0, 9) == 0);
            jr_target    = $urandom;
            if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
            jump_en      = ($urandom_range(0, 5) == 0);
            jump_index   = 26'($urandom);
            branch_en    = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom);
            branch_imm   = 16'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
